// File: rtl/dm_bus_bridge.sv
// rtl/dm_bus_bridge.sv - CPU data-side to word-aligned byte-enabled req/ack bus bridge
module dm_bus_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_dm_ctrl,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [2:0] CTRL_WORD = 3'b000;
    localparam logic [2:0] CTRL_HALF = 3'b001;
    localparam logic [2:0] CTRL_HALFU = 3'b010;
    localparam logic [2:0] CTRL_BYTE = 3'b011;
    localparam logic [2:0] CTRL_BYTEU = 3'b100;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [1:0] off_q;
    logic [2:0] ctrl_q;
    logic [2:0] ctrl_n;

    // Undefined encodings behave as word accesses everywhere downstream.
    function automatic logic [2:0] norm_ctrl(input logic [2:0] c);
        return (c > CTRL_BYTEU) ? CTRL_WORD : c;
    endfunction

    function automatic logic is_half(input logic [2:0] c);
        return (c == CTRL_HALF) || (c == CTRL_HALFU);
    endfunction

    function automatic logic is_byte(input logic [2:0] c);
        return (c == CTRL_BYTE) || (c == CTRL_BYTEU);
    endfunction

    function automatic logic misaligned(input logic [2:0] c, input logic [1:0] o);
        if (is_byte(c))
            return 1'b0;
        else if (is_half(c))
            return o[0];
        else
            return o != 2'b00;
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] c, input logic [1:0] o);
        if (is_byte(c))
            return 4'b0001 << o;
        else if (is_half(c))
            return o[1] ? 4'b1100 : 4'b0011;
        else
            return 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] c, input logic [31:0] d);
        if (is_byte(c))
            return {4{d[7:0]}};
        else if (is_half(c))
            return {2{d[15:0]}};
        else
            return d;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] c, input logic [1:0] o,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{o, 3'b000} +: 8];
        h = d[{o[1], 4'b0000} +: 16];
        case (c)
            CTRL_HALF:  return {{16{h[15]}}, h};
            CTRL_HALFU: return {16'h0000, h};
            CTRL_BYTE:  return {{24{b[7]}}, b};
            CTRL_BYTEU: return {24'h000000, b};
            default:    return d;
        endcase
    endfunction

    assign ctrl_n = norm_ctrl(cpu_dm_ctrl);

    // Idle readiness must react to cpu_req in the same cycle to stall the pipeline.
    assign cpu_ready = (state == IDLE) ? !cpu_req : (state != REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            off_q     <= 2'b00;
            ctrl_q    <= CTRL_WORD;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            cpu_rdata <= 32'd0;
            cpu_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        off_q  <= cpu_addr[1:0];
                        ctrl_q <= ctrl_n;
                        if (misaligned(ctrl_n, cpu_addr[1:0])) begin
                            state     <= ERR;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= 32'd0;
                        end else begin
                            state     <= REQ;
                            cnt       <= 8'd0;
                            bus_req   <= 1'b1;
                            bus_we    <= cpu_we;
                            bus_addr  <= {cpu_addr[31:2], 2'b00};
                            bus_be    <= be_of(ctrl_n, cpu_addr[1:0]);
                            bus_wdata <= wdata_of(ctrl_n, cpu_wdata);
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        state     <= DONE;
                        cpu_rdata <= extract(ctrl_q, off_q, bus_rdata);
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_be    <= 4'b0000;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ERR;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= 32'd0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_be    <= 4'b0000;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    state   <= IDLE;
                    cpu_err <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// tb/tb_dm_bus_bridge.sv - randomized self-checking bench for dm_bus_bridge
module tb_dm_bus_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [2:0]  cpu_dm_ctrl = 3'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    dm_bus_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_dm_ctrl(cpu_dm_ctrl),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .cpu_err(cpu_err),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] c);
        if (c == 3'd1 || c == 3'd2) return 2;
        if (c == 3'd3 || c == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input logic [1:0] o,
                                               input logic [31:0] rv);
        int          n;
        logic [31:0] v;
        logic [31:0] mask;
        n = access_size(c);
        if (n == 4) return rv;
        mask = (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        v = (rv >> (8 * int'(o))) & mask;
        if ((c == 3'd1 || c == 3'd3) && ((v & ((mask >> 1) + 32'd1)) != 32'd0))
            v = v | ~mask;
        return v;
    endfunction

    // w = bus wait cycles before ack; w >= TO means the bus never answers.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic [2:0] c, input int w, input logic [31:0] rv);
        int          n;
        logic        mis;
        logic        tmo;
        logic [3:0]  be_e;
        logic [31:0] wd_e;
        logic [31:0] rd_e;
        int          exp_req;
        int          req_cycles;
        int          low;
        n    = access_size(c);
        mis  = (int'(a[1:0]) % n) != 0;
        tmo  = !mis && (w >= TO);
        be_e = 4'(((1 << n) - 1) << int'(a[1:0]));
        if (n == 4)      wd_e = wd;
        else if (n == 2) wd_e = (wd & 32'h0000_FFFF) * 32'h0001_0001;
        else             wd_e = (wd & 32'h0000_00FF) * 32'h0101_0101;
        rd_e    = model_load(c, a[1:0], rv);
        exp_req = mis ? 0 : (tmo ? TO : w + 1);

        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_dm_ctrl = c;
        #1;
        check("ready_on_req", 32'(cpu_ready), 32'd0);
        low = (cpu_ready == 1'b0) ? 1 : 0;
        req_cycles = 0;
        for (int k = 0; k < TO + 2; k++) begin
            @(negedge clk);
            cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
            cpu_we = 1'($urandom); cpu_dm_ctrl = 3'($urandom);
            bus_ack = 1'b0; bus_rdata = $urandom;
            #1;
            if (!bus_req) break;
            req_cycles++;
            if (!cpu_ready) low++;
            check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
            check("bus_be", 32'(bus_be), 32'(be_e));
            check("bus_we", 32'(bus_we), 32'(we));
            check("bus_wdata", bus_wdata, wd_e);
            if (k == w) begin
                bus_ack = 1'b1;
                bus_rdata = rv;
            end
        end
        check("req_cycles", 32'(req_cycles), 32'(exp_req));
        check("ready_low", 32'(low), 32'(exp_req + 1));
        check("end_ready", 32'(cpu_ready), 32'd1);
        check("end_err", 32'(cpu_err), 32'(mis || tmo));
        check("end_rdata", cpu_rdata, (mis || tmo) ? 32'd0 : rd_e);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("idle_ready", 32'(cpu_ready), 32'd1);
        check("idle_err", 32'(cpu_err), 32'd0);
        check("idle_req", 32'(bus_req), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  c;
        int          w;

        repeat (2) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_ready", 32'(cpu_ready), 32'd1);
        check("rst_err", 32'(cpu_err), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        reset = 1'b0;

        access(32'h0000_0100, 32'h0, 1'b0, 3'b000, 1, 32'hDEAD_BEEF);
        access(32'h0000_0203, 32'h0, 1'b0, 3'b011, 0, 32'h80FF_1234);
        access(32'h0000_0203, 32'h0, 1'b0, 3'b100, 0, 32'h80FF_1234);
        access(32'h0000_0302, 32'h0000_ABCD, 1'b1, 3'b001, 0, 32'h0);
        access(32'h0000_0401, 32'h1234_5678, 1'b1, 3'b000, 0, 32'h0);
        access(32'h0000_0600, 32'h0, 1'b0, 3'b000, 100, 32'h0);

        // Late ack in IDLE must not start or complete anything.
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("late_ack_req", 32'(bus_req), 32'd0);
        check("late_ack_err", 32'(cpu_err), 32'd0);
        check("late_ack_ready", 32'(cpu_ready), 32'd1);

        // Reset during REQ abandons the access at once.
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h0000_0500; cpu_we = 1'b0; cpu_dm_ctrl = 3'b000;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus_req), 32'd0);
        check("mid_rst_ready", 32'(cpu_ready), 32'd1);
        check("mid_rst_err", 32'(cpu_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        access(32'h0000_0704, 32'h0, 1'b0, 3'b000, 2, 32'h0BAD_F00D);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            c = 3'($urandom_range(0, 7));
            w = ($urandom_range(0, 9) == 0) ? TO + 3 : $urandom_range(0, 4);
            access(a, $urandom, 1'($urandom), c, w, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
